// File: rtl/frog_game_ctrl.sv
// Game-state controller for the frog/obstacle game: rectangle overlap per obstacle,
// lives, score, hit flash, respawn and game-over, all advanced on end-of-frame pulses.
module frog_game_ctrl #(
    parameter int N_OBJ      = 3,
    parameter int CW         = 12,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int GOAL_Y     = 40,
    parameter int SCORE_W    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_animate,
    input  logic                  i_start,
    input  logic [CW-1:0]         i_frog_x1,
    input  logic [CW-1:0]         i_frog_x2,
    input  logic [CW-1:0]         i_frog_y1,
    input  logic [CW-1:0]         i_frog_y2,
    input  logic [N_OBJ*CW-1:0]   i_obj_x1,
    input  logic [N_OBJ*CW-1:0]   i_obj_x2,
    input  logic [N_OBJ*CW-1:0]   i_obj_y1,
    input  logic [N_OBJ*CW-1:0]   i_obj_y2,
    input  logic [N_OBJ-1:0]      i_obj_en,
    output logic [N_OBJ-1:0]      o_hit_mask,
    output logic                  o_dead,
    output logic                  o_respawn,
    output logic [3:0]            o_lives,
    output logic [SCORE_W-1:0]    o_score,
    output logic [2:0]            o_state,
    output logic                  o_game_over
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        HIT     = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4
    } state_t;

    localparam logic [7:0]    HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [CW-1:0] GOAL_LINE  = CW'(GOAL_Y);

    state_t               state, state_n;
    logic [N_OBJ-1:0]     overlap;
    logic [7:0]           hit_cnt, hit_cnt_n;
    logic [3:0]           lives_n;
    logic [SCORE_W-1:0]   score_n;
    logic                 respawn_n;

    // Strict compares so boxes that merely share an edge do not collide.
    for (genvar k = 0; k < N_OBJ; k++) begin : g_overlap
        assign overlap[k] = i_obj_en[k]
                          && (i_frog_x1 < i_obj_x2[k*CW +: CW])
                          && (i_frog_x2 > i_obj_x1[k*CW +: CW])
                          && (i_frog_y1 < i_obj_y2[k*CW +: CW])
                          && (i_frog_y2 > i_obj_y1[k*CW +: CW]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_hit_mask <= '0;
            o_respawn  <= 1'b0;
            o_lives    <= LIVES_INIT;
            o_score    <= '0;
            hit_cnt    <= '0;
        end else begin
            state      <= state_n;
            o_hit_mask <= overlap;
            o_respawn  <= respawn_n;
            o_lives    <= lives_n;
            o_score    <= score_n;
            hit_cnt    <= hit_cnt_n;
        end
    end

    // Start requests are level-sampled on any cycle; everything else waits for a frame pulse.
    always_comb begin
        state_n   = state;
        hit_cnt_n = hit_cnt;
        lives_n   = o_lives;
        score_n   = o_score;
        respawn_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    state_n   = RESPAWN;
                    respawn_n = 1'b1;
                end
            end
            PLAY: begin
                if (i_animate) begin
                    if (|o_hit_mask) begin
                        state_n   = HIT;
                        hit_cnt_n = '0;
                        if (o_lives != 4'd0)
                            lives_n = o_lives - 4'd1;
                    end else if (i_frog_y1 <= GOAL_LINE) begin
                        state_n   = RESPAWN;
                        respawn_n = 1'b1;
                        if (o_score != '1)
                            score_n = o_score + SCORE_W'(1);
                    end
                end
            end
            HIT: begin
                if (i_animate) begin
                    if (hit_cnt == HIT_LAST) begin
                        if (o_lives == 4'd0) begin
                            state_n = OVER;
                        end else begin
                            state_n   = RESPAWN;
                            respawn_n = 1'b1;
                        end
                    end else begin
                        hit_cnt_n = hit_cnt + 8'd1;
                    end
                end
            end
            RESPAWN: begin
                if (i_animate)
                    state_n = PLAY;
            end
            OVER: begin
                if (i_start) begin
                    state_n   = RESPAWN;
                    respawn_n = 1'b1;
                    lives_n   = LIVES_INIT;
                    score_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_state     = state;
    assign o_dead      = (state == HIT);
    assign o_game_over = (state == OVER);

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed self-checking bench for frog_game_ctrl: reset, start, collisions,
// edge cases, goals, game over, mid-hit reset and score saturation.
module tb_frog_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        animate = 1'b0;
    logic        start = 1'b0;
    logic [11:0] frog_x1, frog_x2, frog_y1, frog_y2;
    logic [35:0] obj_x1, obj_x2, obj_y1, obj_y2;
    logic [2:0]  obj_en;
    logic [2:0]  hit_mask;
    logic        dead, respawn, game_over;
    logic [3:0]  lives;
    logic [7:0]  score;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    frog_game_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_animate(animate), .i_start(start),
        .i_frog_x1(frog_x1), .i_frog_x2(frog_x2), .i_frog_y1(frog_y1), .i_frog_y2(frog_y2),
        .i_obj_x1(obj_x1), .i_obj_x2(obj_x2), .i_obj_y1(obj_y1), .i_obj_y2(obj_y2),
        .i_obj_en(obj_en), .o_hit_mask(hit_mask), .o_dead(dead), .o_respawn(respawn),
        .o_lives(lives), .o_score(score), .o_state(state), .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        animate = 1'b1;
        tick();
        animate = 1'b0;
    endtask

    task automatic set_frog(input logic [11:0] x1, x2, y1, y2);
        frog_x1 = x1; frog_x2 = x2; frog_y1 = y1; frog_y2 = y2;
    endtask

    task automatic set_obj(input int k, input logic [11:0] x1, x2, y1, y2);
        obj_x1[k*12 +: 12] = x1; obj_x2[k*12 +: 12] = x2;
        obj_y1[k*12 +: 12] = y1; obj_y2[k*12 +: 12] = y2;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++;
        if ({lives, score} !== {4'd3, 8'd0}) begin errors++; $display("FAIL reset_lives_score got %0d/%0d exp 3/0", lives, score); end
        checks++;
        if ({hit_mask, respawn, dead, game_over} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {hit_mask, respawn, dead, game_over}); end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({state, respawn} !== {3'd3, 1'b1}) begin errors++; $display("FAIL start_respawn got state %0d respawn %b exp 3/1", state, respawn); end
        tick();
        checks++;
        if ({state, respawn} !== {3'd3, 1'b0}) begin errors++; $display("FAIL respawn_one_cycle got state %0d respawn %b exp 3/0", state, respawn); end
        pulse();
        checks++;
        if ({state, lives, score} !== {3'd1, 4'd3, 8'd0}) begin errors++; $display("FAIL start_play got %0d/%0d/%0d exp 1/3/0", state, lives, score); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({state, respawn} !== {3'd1, 1'b0}) begin errors++; $display("FAIL start_ignored_play got %0d/%b exp 1/0", state, respawn); end
    endtask

    task automatic test_hit();
        int dead_frames;
        set_obj(0, 110, 200, 105, 130);
        obj_en = 3'b001;
        tick();
        checks++;
        if (hit_mask !== 3'b001) begin errors++; $display("FAIL hit_mask got %b exp 001", hit_mask); end
        pulse();
        checks++;
        if ({state, lives, dead} !== {3'd2, 4'd2, 1'b1}) begin errors++; $display("FAIL hit_enter got %0d/%0d/%b exp 2/2/1", state, lives, dead); end
        obj_en = 3'b000;
        dead_frames = 0;
        for (int i = 0; i < 60; i++) begin
            if (dead) dead_frames++;
            pulse();
        end
        checks++;
        if (dead_frames !== 60) begin errors++; $display("FAIL hit_frames got %0d exp 60", dead_frames); end
        checks++;
        if ({state, respawn, dead} !== {3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL hit_exit got %0d/%b/%b exp 3/1/0", state, respawn, dead); end
        pulse();
        checks++;
        if ({state, lives} !== {3'd1, 4'd2}) begin errors++; $display("FAIL hit_back_play got %0d/%0d exp 1/2", state, lives); end
    endtask

    task automatic test_edges();
        set_frog(90, 110, 100, 115);
        obj_en = 3'b001;
        tick();
        checks++;
        if (hit_mask !== 3'b000) begin errors++; $display("FAIL edge_touch_x got %b exp 000", hit_mask); end
        pulse();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL edge_no_hit_state got %0d exp 1", state); end
        set_frog(100, 120, 100, 115);
        obj_en = 3'b000;
        tick();
        pulse();
        checks++;
        if ({state, hit_mask} !== {3'd1, 3'b000}) begin errors++; $display("FAIL disabled_obj got %0d/%b exp 1/000", state, hit_mask); end
        set_obj(1, 100, 120, 115, 130);
        obj_en = 3'b010;
        tick();
        checks++;
        if (hit_mask !== 3'b000) begin errors++; $display("FAIL edge_touch_y got %b exp 000", hit_mask); end
        set_obj(2, 115, 130, 110, 120);
        obj_en = 3'b100;
        tick();
        checks++;
        if (hit_mask !== 3'b100) begin errors++; $display("FAIL obj2_mask got %b exp 100", hit_mask); end
        obj_en = 3'b000;
        tick();
        checks++;
        if ({state, hit_mask} !== {3'd1, 3'b000}) begin errors++; $display("FAIL no_animate_hold got %0d/%b exp 1/000", state, hit_mask); end
    endtask

    task automatic test_goal();
        set_frog(100, 120, 41, 56);
        tick();
        pulse();
        checks++;
        if ({state, score} !== {3'd1, 8'd0}) begin errors++; $display("FAIL goal_y41 got %0d/%0d exp 1/0", state, score); end
        set_frog(100, 120, 40, 55);
        pulse();
        checks++;
        if ({state, score, respawn} !== {3'd3, 8'd1, 1'b1}) begin errors++; $display("FAIL goal_y40 got %0d/%0d/%b exp 3/1/1", state, score, respawn); end
        set_frog(100, 120, 100, 115);
        pulse();
        set_frog(100, 120, 40, 55);
        set_obj(0, 110, 200, 45, 130);
        obj_en = 3'b001;
        tick();
        pulse();
        checks++;
        if ({state, score, lives} !== {3'd2, 8'd1, 4'd1}) begin errors++; $display("FAIL hit_over_goal got %0d/%0d/%0d exp 2/1/1", state, score, lives); end
        obj_en = 3'b000;
        set_frog(100, 120, 100, 115);
        repeat (60) pulse();
        pulse();
        checks++;
        if ({state, lives} !== {3'd1, 4'd1}) begin errors++; $display("FAIL goal_hit_recover got %0d/%0d exp 1/1", state, lives); end
    endtask

    task automatic test_game_over();
        apply_reset();
        begin_game();
        set_frog(100, 120, 40, 55);
        pulse();
        set_frog(100, 120, 100, 115);
        pulse();
        set_obj(0, 110, 200, 105, 130);
        for (int h = 0; h < 3; h++) begin
            obj_en = 3'b001;
            tick();
            pulse();
            obj_en = 3'b000;
            repeat (60) pulse();
            if (h < 2) pulse();
        end
        checks++;
        if ({state, game_over, lives, score} !== {3'd4, 1'b1, 4'd0, 8'd1}) begin errors++; $display("FAIL game_over got %0d/%b/%0d/%0d exp 4/1/0/1", state, game_over, lives, score); end
        checks++;
        if ({respawn, dead} !== 2'b00) begin errors++; $display("FAIL over_flags got %b exp 00", {respawn, dead}); end
        pulse();
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL over_hold got %0d exp 4", state); end
        animate = 1'b1;
        start = 1'b1;
        tick();
        animate = 1'b0;
        start = 1'b0;
        checks++;
        if ({state, respawn, lives, score, game_over} !== {3'd3, 1'b1, 4'd3, 8'd0, 1'b0}) begin errors++; $display("FAIL restart got %0d/%b/%0d/%0d/%b exp 3/1/3/0/0", state, respawn, lives, score, game_over); end
        pulse();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL restart_play got %0d exp 1", state); end
    endtask

    task automatic test_reset_mid_hit();
        obj_en = 3'b001;
        tick();
        pulse();
        obj_en = 3'b000;
        repeat (30) pulse();
        checks++;
        if ({state, lives} !== {3'd2, 4'd2}) begin errors++; $display("FAIL mid_hit got %0d/%0d exp 2/2", state, lives); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, lives, dead, respawn, hit_mask} !== {3'd0, 4'd3, 1'b0, 1'b0, 3'b000}) begin errors++; $display("FAIL async_reset got %0d/%0d/%b/%b/%b exp 0/3/0/0/000", state, lives, dead, respawn, hit_mask); end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({state, respawn} !== {3'd0, 1'b0}) begin errors++; $display("FAIL post_reset got %0d/%b exp 0/0", state, respawn); end
    endtask

    task automatic test_score_sat();
        begin_game();
        set_frog(100, 120, 40, 55);
        for (int i = 0; i < 255; i++) begin
            pulse();
            pulse();
        end
        checks++;
        if ({state, score} !== {3'd1, 8'd255}) begin errors++; $display("FAIL score_255 got %0d/%0d exp 1/255", state, score); end
        pulse();
        checks++;
        if ({state, score, respawn} !== {3'd3, 8'd255, 1'b1}) begin errors++; $display("FAIL score_sat got %0d/%0d/%b exp 3/255/1", state, score, respawn); end
        set_frog(100, 120, 100, 115);
    endtask

    initial begin
        set_frog(100, 120, 100, 115);
        obj_x1 = '0; obj_x2 = '0; obj_y1 = '0; obj_y2 = '0;
        obj_en = 3'b000;
        test_reset();
        test_start();
        test_hit();
        test_edges();
        test_goal();
        test_game_over();
        test_reset_mid_hit();
        test_score_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
- Frame-synchronous game-state controller for the frog/obstacle VGA game.
- Tests the frog box against N_OBJ obstacle boxes using true rectangle overlap.
- Manages lives, score, hit flash, respawn and game-over in an FSM.
- Sits between the object animators and the top-level colour mux. Drives the frog's dead/respawn inputs and the per-object hit highlighting.

Parameters:
- N_OBJ, 3, number of obstacle channels.
- CW, 12, coordinate width, matching the animators' 12-bit outputs.
- LIVES, 3, lives loaded at start; range 1..15.
- HIT_FRAMES, 60, i_animate pulses spent in HIT, range 1..255.
- GOAL_Y, 40, frog reaches the goal when frog y1 <= GOAL_Y.
- SCORE_W, 8, score counter width.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_animate  in  1  one-cycle end-of-frame pulse.
- i_start  in  1  start/restart request, level-sampled.
- i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2  in  CW each  frog box.
- i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2  in  N_OBJ*CW each  packed obstacle boxes; object k occupies bits [k*CW +: CW].
- i_obj_en  in  N_OBJ  per-object enable; a disabled object never hits.
- o_hit_mask  out  N_OBJ  registered per-object overlap.
- o_dead  out  1  high while in HIT.
- o_respawn  out  1  one-cycle pulse; frog returns to its start position.
- o_lives  out  4  remaining lives.
- o_score  out  SCORE_W  goals reached.
- o_state  out  3  IDLE=0, PLAY=1, HIT=2, RESPAWN=3, OVER=4.
- o_game_over  out  1  high in OVER.

Behaviour:

Reset (i_rst high, asynchronous) forces:
- state IDLE
- o_hit_mask 0, o_dead 0, o_respawn 0
- o_lives LIVES, o_score 0
- o_game_over 0, hit-frame counter 0

Overlap test:
- Object k overlaps when all of the following hold, with unsigned compares: frog_x1 < obj_x2, frog_x2 > obj_x1, frog_y1 < obj_y2, frog_y2 > obj_y1, and i_obj_en[k] = 1.
- Edge-touching boxes are not a hit.
- o_hit_mask is registered every cycle, giving 1-cycle latency from the inputs.

The FSM acts only on cycles where i_animate = 1, using the current o_hit_mask, except where noted.

- IDLE: i_start = 1 on any cycle moves to RESPAWN and pulses o_respawn.
- PLAY, on i_animate:
  - Any hit (|o_hit_mask) goes to HIT: o_lives decrements, counter clears.
  - Otherwise, if frog_y1 <= GOAL_Y: o_score increments (saturating at all-ones), go to RESPAWN, pulse o_respawn.
  - A hit takes priority over a goal in the same frame.
  - No i_animate: hold.
- HIT:
  - o_dead = 1.
  - Counter increments on each i_animate.
  - When the counter reaches HIT_FRAMES-1 and i_animate = 1:
    - if o_lives = 0, go to OVER;
    - else go to RESPAWN and pulse o_respawn.
  - o_hit_mask keeps updating but is ignored.
- RESPAWN:
  - Collisions are ignored.
  - The next i_animate moves to PLAY.
  - This gives a grace frame while the frog repositions.
- OVER:
  - o_game_over = 1.
  - i_start = 1 reloads o_lives = LIVES, clears o_score, goes to RESPAWN and pulses o_respawn.
- i_start is ignored in PLAY, HIT and RESPAWN.

Other rules:
- o_respawn is exactly one cycle wide and is asserted in the cycle after the transition decision.
- o_lives never underflows; the decrement only happens from PLAY, and the OVER check prevents re-entry.
- Reset asserted mid-HIT or mid-RESPAWN returns to IDLE immediately, with no o_respawn pulse.
- i_animate and i_start in the same cycle in OVER: i_start wins; the frame is not counted.

Test Plan:
1. Reset, then i_start for 1 cycle, then 1 animate -> o_respawn pulses once, o_state goes 3 then 1, o_lives = 4'd3, o_score = 0.
2. Frog (100,100)-(120,115); obj0 (110,105)-(200,130), enabled; animate -> o_hit_mask = 3'b001, state HIT, o_lives = 2, o_dead high for exactly 60 animates, then RESPAWN, then PLAY.
3. Edge touch: frog x2 = 110, obj0 x1 = 110 -> o_hit_mask = 0, no state change. Same geometry with i_obj_en[0] = 0 -> no hit.
4. Frog y1 = 40 with no overlap, animate -> o_score = 1, o_respawn pulse. Frog y1 = 40 plus an overlap in the same frame -> HIT, o_score unchanged.
5. Three hits in succession -> after the third HIT window, o_state = 4, o_game_over = 1, o_lives = 0. Then i_start -> o_lives = 3, o_score = 0, RESPAWN.
6. Assert i_rst mid-HIT (frame 30) -> outputs return to reset values asynchronously, o_state = 0, no o_respawn pulse.
7. Force o_score to 255, then a goal -> o_score stays 255.
